// File: rtl/audio_pkg.sv
// audio_pkg: shared effect ids, scheduler states and effect lengths
package audio_pkg;

    localparam logic [1:0] SFX_COIN    = 2'd0;
    localparam logic [1:0] SFX_JUMP    = 2'd1;
    localparam logic [1:0] SFX_POWERUP = 2'd2;
    localparam logic [1:0] SFX_DEATH   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    // index of the final step of each effect
    localparam logic [3:0] SFX_LAST [4] = '{4'd1, 4'd3, 4'd7, 4'd11};

    function automatic logic [1:0] prio_id(input logic [3:0] p);
        return p[3] ? SFX_DEATH : p[2] ? SFX_POWERUP : p[1] ? SFX_JUMP : SFX_COIN;
    endfunction

endpackage

// File: rtl/sfx_rom.sv
// sfx_rom: combinational effect tone table, indexed by effect id and step
module sfx_rom
    import audio_pkg::*;
(
    input  logic [1:0]  id,
    input  logic [3:0]  step,
    output logic [31:0] tone,
    output logic        last
);

    localparam logic [31:0] TONES [4][16] = '{
        '{988, 1319, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{523, 659, 784, 1047, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{523, 659, 784, 1047, 1319, 1568, 2093, 2637, 0, 0, 0, 0, 0, 0, 0, 0},
        '{988, 932, 880, 831, 784, 740, 698, 659, 622, 587, 554, 523, 0, 0, 0, 0}
    };

    assign tone = TONES[id][step];
    assign last = step >= SFX_LAST[id];

endmodule

// File: rtl/sfx_bgm_scheduler.sv
// sfx_bgm_scheduler: beat-aligned arbitration of the tone generator between BGM
// and four prioritised sound effects, with preemption and a post-effect gap.
module sfx_bgm_scheduler
    import audio_pkg::*;
#(
    parameter int SFX_STEPS_MAX = 16,
    parameter int GAP_BEATS     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        beat_tick,
    input  logic        bgm_en,
    input  logic [31:0] bgm_tone,
    input  logic [3:0]  sfx_req,
    output logic [31:0] tone_freq,
    output logic        mute,
    output logic        bgm_pause,
    output logic        sfx_busy,
    output logic [1:0]  sfx_id
);

    localparam logic [1:0] GAP_INIT = 2'(GAP_BEATS > 0 ? GAP_BEATS - 1 : 0);
    localparam logic [3:0] STEP_SAT = 4'(SFX_STEPS_MAX - 1);

    state_t      state_q, state_d;
    logic [3:0]  pend_q, pend_d, step_q, step_d, req_ok, avail;
    logic [1:0]  id_q, id_d, gap_q, gap_d;
    logic [31:0] tone_q, tone_d, rom_tone;
    logic        last_q, last_d, pause_q, pause_d, cur_last, grant;

    // addressed with the next step so the registered tone lines up with the grant
    sfx_rom u_rom (.id(id_d), .step(step_d), .tone(rom_tone), .last(last_d));

    assign cur_last = last_q || step_q == STEP_SAT;

    always_comb begin
        req_ok  = sfx_req & ~(state_q == S_PLAY ? 4'b0001 << id_q : 4'b0000);
        avail   = pend_q | req_ok;
        state_d = state_q;
        id_d    = id_q;
        step_d  = step_q;
        gap_d   = gap_q;
        grant   = 1'b0;
        if (beat_tick) begin
            case (state_q)
                S_IDLE: grant = |avail;
                S_PLAY:
                    if (|(avail & (4'b1110 << id_q)) || (cur_last && |avail)) grant = 1'b1;
                    else if (cur_last) begin
                        state_d = GAP_BEATS == 0 ? S_IDLE : S_GAP;
                        gap_d   = GAP_INIT;
                    end else step_d = step_q + 4'd1;
                S_GAP:
                    if (|avail) grant = 1'b1;
                    else if (gap_q == 2'd0) state_d = S_IDLE;
                    else gap_d = gap_q - 2'd1;
                default: state_d = S_IDLE;
            endcase
        end
        if (grant) begin
            state_d = S_PLAY;
            id_d    = prio_id(avail);
            step_d  = 4'd0;
        end
        pend_d = avail & ~(grant ? 4'b0001 << prio_id(avail) : 4'b0000);
    end

    // between ticks the next state equals the current one, so this also tracks BGM in IDLE
    always_comb begin
        tone_d  = state_d == S_PLAY ? rom_tone : state_d == S_GAP ? 32'd0 : bgm_en ? bgm_tone : 32'd0;
        pause_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            step_q  <= '0;
            id_q    <= '0;
            gap_q   <= '0;
            tone_q  <= '0;
            last_q  <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
            id_q    <= id_d;
            gap_q   <= gap_d;
            tone_q  <= tone_d;
            last_q  <= last_d;
            pause_q <= pause_d;
        end
    end

    assign tone_freq = tone_q;
    assign mute      = tone_q == 32'd0;
    assign bgm_pause = pause_q;
    assign sfx_busy  = state_q == S_PLAY;
    assign sfx_id    = id_q;

endmodule

// File: doc/sfx_bgm_scheduler.md
# sfx_bgm_scheduler

Shares the single speaker tone generator between the background-music track and four game sound effects. It sits between the beat-rate pulse source, the BGM tone lookup and the tone PWM generator. On beat boundaries it selects either the BGM tone or a sound-effect step from an internal effect ROM, and freezes the BGM beat counter while an effect is playing. Arbitration is by fixed priority, with preemption on beat boundaries.

## Interface
- `SFX_STEPS_MAX`, 16: maximum steps per effect; the step counter is 4 bits.
- `GAP_BEATS`, 1: silent beats inserted after an effect before BGM resumes (0..3).
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `beat_tick`  in  1  one-cycle pulse per beat, in the `clk` domain
- `bgm_en`  in  1  BGM enabled; when low, idle output is silent
- `bgm_tone`  in  32  current BGM tone in Hz; 0 = rest
- `sfx_req`  in  4  one-cycle request pulses. [3] death, [2] power-up, [1] jump, [0] coin. Priority is [3] > [2] > [1] > [0].
- `tone_freq`  out  32  tone to the PWM generator, registered
- `mute`  out  1  high when `tone_freq` = 0
- `bgm_pause`  out  1  hold enable for the BGM beat counter, registered
- `sfx_busy`  out  1  high in PLAY
- `sfx_id`  out  2  effect currently playing; valid only while `sfx_busy` is high

## Operation
- **Pending register** (`pend`, 4 bits):
  - A `sfx_req` bit sets its `pend` bit.
  - A grant clears the granted bit.
  - A request for the id currently in PLAY is dropped and not latched.
  - A request arriving in the same cycle as `beat_tick` is eligible at that tick.
- **State machine:** IDLE, PLAY, GAP. All decisions are taken only on cycles where `beat_tick` = 1.
  - **IDLE:** if `pend` ≠ 0, grant the highest-priority bit, set step to 0, go to PLAY. Otherwise stay in IDLE.
  - **PLAY, higher-priority bit pending:** preempt. Grant that bit, restart step at 0, stay in PLAY. The preempted effect is discarded, not resumed.
  - **PLAY, step is the last step (ROM `last` = 1):**
    - go to GAP with the gap counter = `GAP_BEATS`−1;
    - if `GAP_BEATS` = 0, take the IDLE decision directly instead.
  - **PLAY, otherwise:** step increments by 1. The step saturates at `SFX_STEPS_MAX`−1, and that step is treated as last.
  - **GAP:**
    - if `pend` ≠ 0, grant and go to PLAY, with the gap abandoned;
    - else if the gap counter = 0, go to IDLE;
    - else decrement the gap counter.
- **Output mux** (the registered value loaded on each `beat_tick`, and also on any state change):
  - IDLE: `bgm_en` ? `bgm_tone` : 0
  - PLAY: `rom_tone(sfx_id, step)`
  - GAP: 0
- `mute` = (`tone_freq` == 0).
- `bgm_pause` = 1 in PLAY and GAP, 0 in IDLE.
- Changes to `bgm_tone` in IDLE are also tracked between ticks, so BGM passes through with 1 cycle of latency.

## Timing
- **Reset values:** state IDLE, `pend` = 0, `tone_freq` = 0, `mute` = 1, `bgm_pause` = 0, `sfx_busy` = 0, `sfx_id` = 0.
- **Grant latency:** a grant on tick cycle T shows `tone_freq`, `sfx_busy` and `bgm_pause` updated at T+1.
- **Worst-case start:** a request lands just after a tick and waits one full beat.
- **BGM freeze:** `bgm_pause` rises at T+1. The BGM counter consumes the tick at T itself, so the BGM note that was sounding resumes at the next beat after returning to IDLE.
- **Simultaneous requests:** the highest-priority bit is granted; the others remain pending and play in priority order.
- **Reset mid-effect:** immediate silence; pending requests are lost.

## Structure
- Shared package `audio_pkg`:
  - effect-id constants `SFX_COIN` = 0, `SFX_JUMP` = 1, `SFX_POWERUP` = 2, `SFX_DEATH` = 3;
  - state encoding;
  - effect lengths.
- Sub-module `sfx_rom`: combinational; inputs `id`[1:0] and `step`[3:0]; outputs `tone`[31:0] and `last`. Contents:
  - coin: 988, 1319 (2 steps)
  - jump: 523, 659, 784, 1047 (4 steps)
  - power-up: 8 steps
  - death: 12 steps
- Scheduler FSM, pending register and output mux live in the top level.

## Test plan
- **Reset, then BGM passthrough:** `bgm_en` = 1, `bgm_tone` = 440 → `tone_freq` = 440 one cycle later, `mute` = 0, `bgm_pause` = 0.
- **Coin:** pulse `sfx_req`[0] mid-beat, with `GAP_BEATS` = 1 → on the next two ticks:
  - `tone_freq` = 988, then 1319, with `sfx_busy` = 1 and `bgm_pause` = 1;
  - then one beat of 0;
  - then 440 with `bgm_pause` = 0.
- **Simultaneous requests:** `sfx_req` = 4'b0011 in one cycle → jump's 4 steps play first (523…1047), then coin (988, 1319) directly after, with no GAP between them.
- **Preemption:** death requested during jump step 1 → at the next tick `sfx_id` = 3, step 0; jump never resumes; `pend` = 0 afterwards.
- **Re-request of the playing id:** pulse `sfx_req`[1] during jump → ignored; IDLE is reached after 4 steps plus the gap.
- **Reset mid-effect:** reset during power-up step 3 → next cycle `tone_freq` = 0, `sfx_busy` = 0; after reset, the IDLE/BGM path resumes.
